// File: rtl/video_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module : video_mode_pkg
// Brief  : Mode encodings, timing-set record, per-mode timing constants and
//          controller state encoding for the video mode controller.
// Rev    : 1.0  initial release
// ============================================================================
package video_mode_pkg;

    localparam logic [1:0] c_MODE_1080P = 2'd0;
    localparam logic [1:0] c_MODE_1080I = 2'd1;
    localparam logic [1:0] c_MODE_720P  = 2'd2;
    localparam logic [1:0] c_MODE_480P  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_BLANK      = 3'd2,
        S_APPLY      = 3'd3,
        S_SETTLE     = 3'd4,
        S_UNBLANK    = 3'd5
    } vmc_state_t;

    typedef struct packed {
        logic [11:0] v_total_0;
        logic [11:0] v_fp_0;
        logic [11:0] v_bp_0;
        logic [11:0] v_sync_0;
        logic [11:0] v_total_1;
        logic [11:0] v_fp_1;
        logic [11:0] v_bp_1;
        logic [11:0] v_sync_1;
        logic [11:0] h_total;
        logic [11:0] h_fp;
        logic [11:0] h_bp;
        logic [11:0] h_sync;
        logic [11:0] hv_offset_0;
        logic [11:0] hv_offset_1;
        logic [19:0] ramp_step;
        logic        interlaced;
    } timing_set_t;

    localparam timing_set_t c_TIMING_1080P = '{
        v_total_0: 12'd1125, v_fp_0: 12'd4, v_bp_0: 12'd36, v_sync_0: 12'd5,
        v_total_1: 12'd0,    v_fp_1: 12'd0, v_bp_1: 12'd0,  v_sync_1: 12'd0,
        h_total: 12'd2200, h_fp: 12'd88, h_bp: 12'd148, h_sync: 12'd44,
        hv_offset_0: 12'd0, hv_offset_1: 12'd0,
        ramp_step: 20'h00222, interlaced: 1'b0};

    localparam timing_set_t c_TIMING_1080I = '{
        v_total_0: 12'd562, v_fp_0: 12'd2, v_bp_0: 12'd15, v_sync_0: 12'd5,
        v_total_1: 12'd563, v_fp_1: 12'd2, v_bp_1: 12'd16, v_sync_1: 12'd5,
        h_total: 12'd2200, h_fp: 12'd88, h_bp: 12'd148, h_sync: 12'd44,
        hv_offset_0: 12'd0, hv_offset_1: 12'd1100,
        ramp_step: 20'h00222, interlaced: 1'b1};

    localparam timing_set_t c_TIMING_720P = '{
        v_total_0: 12'd750, v_fp_0: 12'd5, v_bp_0: 12'd20, v_sync_0: 12'd5,
        v_total_1: 12'd0,   v_fp_1: 12'd0, v_bp_1: 12'd0,  v_sync_1: 12'd0,
        h_total: 12'd1650, h_fp: 12'd110, h_bp: 12'd220, h_sync: 12'd40,
        hv_offset_0: 12'd0, hv_offset_1: 12'd0,
        ramp_step: 20'h00333, interlaced: 1'b0};

    localparam timing_set_t c_TIMING_480P = '{
        v_total_0: 12'd525, v_fp_0: 12'd10, v_bp_0: 12'd32, v_sync_0: 12'd3,
        v_total_1: 12'd0,   v_fp_1: 12'd0,  v_bp_1: 12'd0,  v_sync_1: 12'd0,
        h_total: 12'd880, h_fp: 12'd24, h_bp: 12'd96, h_sync: 12'd40,
        hv_offset_0: 12'd0, hv_offset_1: 12'd0,
        ramp_step: 20'h005B0, interlaced: 1'b0};

    function automatic logic [11:0] active_pix(input timing_set_t t);
        return t.h_total - (t.h_fp + t.h_bp + t.h_sync);
    endfunction

    // Progressive modes carry an all-zero field 1, so only field 0 counts.
    function automatic logic [11:0] active_lines(input timing_set_t t);
        logic [11:0] f0;
        logic [11:0] f1;
        f0 = t.v_total_0 - (t.v_fp_0 + t.v_bp_0 + t.v_sync_0);
        f1 = t.v_total_1 - (t.v_fp_1 + t.v_bp_1 + t.v_sync_1);
        return t.interlaced ? (f0 + f1) : f0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_mode_rom.sv
`default_nettype none
// ============================================================================
// Module : video_mode_rom
// Brief  : Combinational lookup from mode code to its full timing set.
// Rev    : 1.0  initial release
// ============================================================================
module video_mode_rom
    import video_mode_pkg::*;
(
    input  logic [1:0]  i_mode,
    output timing_set_t o_timing
);

    always_comb begin
        o_timing = c_TIMING_1080P;
        unique case (i_mode)
            c_MODE_1080I: o_timing = c_TIMING_1080I;
            c_MODE_720P:  o_timing = c_TIMING_720P;
            c_MODE_480P:  o_timing = c_TIMING_480P;
            default:      o_timing = c_TIMING_1080P;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/video_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module : video_mode_ctrl
// Brief  : Frame-aligned video mode switcher: blanks output, reloads timing,
//          pulses timing reset, unblanks on the next frame. Optional frame
//          edge watchdog enabled by defining VMC_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter int BLANK_FRAMES   = 2,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic        mode_ack,
    output logic        mode_done,
    output logic        busy,
    input  logic        vs_in,
    output logic        timing_rst,
    output logic        blank,
    output logic [1:0]  cur_mode,
    output logic        interlaced,
    output logic [11:0] v_total_0,
    output logic [11:0] v_fp_0,
    output logic [11:0] v_bp_0,
    output logic [11:0] v_sync_0,
    output logic [11:0] v_total_1,
    output logic [11:0] v_fp_1,
    output logic [11:0] v_bp_1,
    output logic [11:0] v_sync_1,
    output logic [11:0] h_total,
    output logic [11:0] h_fp,
    output logic [11:0] h_bp,
    output logic [11:0] h_sync,
    output logic [11:0] hv_offset_0,
    output logic [11:0] hv_offset_1,
    output logic [11:0] total_active_pix,
    output logic [11:0] total_active_lines,
    output logic [19:0] ramp_step
);

    localparam logic [3:0] c_FRAMES_LAST = 4'(BLANK_FRAMES - 1);
    localparam logic [7:0] c_RST_LAST    = 8'(RST_CYCLES - 1);

    vmc_state_t  r_state;
    vmc_state_t  w_next;
    logic        r_vs_d;
    logic        w_vs_rise;
    logic        w_edge;
    logic        w_accept;
    logic        w_change;
    logic        r_ack;
    logic        r_done;
    logic        r_done_pend;
    logic        r_blank;
    logic        r_timing_rst;
    logic [1:0]  r_sel;
    logic [1:0]  r_cur_mode;
    logic [3:0]  r_frame_cnt;
    logic [7:0]  r_rst_cnt;
    logic [11:0] r_act_pix;
    logic [11:0] r_act_lines;
    timing_set_t w_rom;
    timing_set_t r_timing;

    assign w_vs_rise = vs_in & ~r_vs_d;
    // r_ack masks the cycle where the requester has not yet seen the ack.
    assign w_accept  = (r_state == S_IDLE) && mode_req && !r_ack;
    assign w_change  = w_accept && (mode_sel != r_cur_mode);

`ifdef VMC_TIMEOUT_EN
    localparam int              c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wd;
    logic              w_waiting;

    assign w_waiting = (r_state == S_WAIT_FRAME) || (r_state == S_BLANK) ||
                       (r_state == S_UNBLANK);
    assign w_edge    = w_vs_rise || (w_waiting && (r_wd == c_WD_LAST));

    always_ff @(posedge clk_in) begin
        if (reset || !w_waiting || w_edge || (w_next != r_state)) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end
`else
    // Watchdog limit has no effect in this build.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_edge           = w_vs_rise;
`endif

    video_mode_rom u_rom (
        .i_mode   (r_sel),
        .o_timing (w_rom)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:       if (w_change) w_next = S_WAIT_FRAME;
            S_WAIT_FRAME: if (w_edge) w_next = S_BLANK;
            S_BLANK:      if (w_edge && (r_frame_cnt == c_FRAMES_LAST)) w_next = S_APPLY;
            S_APPLY:      w_next = S_SETTLE;
            S_SETTLE:     if (r_rst_cnt == c_RST_LAST) w_next = S_UNBLANK;
            S_UNBLANK:    if (w_edge) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_vs_d       <= 1'b0;
            r_ack        <= 1'b0;
            r_done       <= 1'b0;
            r_done_pend  <= 1'b0;
            r_blank      <= 1'b0;
            r_timing_rst <= 1'b0;
            r_sel        <= c_MODE_1080P;
            r_cur_mode   <= c_MODE_1080P;
            r_frame_cnt  <= '0;
            r_rst_cnt    <= '0;
            r_timing     <= c_TIMING_1080P;
            r_act_pix    <= active_pix(c_TIMING_1080P);
            r_act_lines  <= active_lines(c_TIMING_1080P);
        end else begin
            r_vs_d      <= vs_in;
            r_ack       <= w_accept;
            r_done_pend <= w_accept && (mode_sel == r_cur_mode);
            r_done      <= r_done_pend || ((r_state == S_UNBLANK) && w_edge);

            if (w_accept) begin
                r_sel <= mode_sel;
            end

            if (w_change) begin
                r_blank <= 1'b1;
            end else if ((r_state == S_UNBLANK) && w_edge) begin
                r_blank <= 1'b0;
            end

            if ((r_state == S_WAIT_FRAME) && w_edge) begin
                r_frame_cnt <= '0;
            end else if ((r_state == S_BLANK) && w_edge) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            r_rst_cnt <= (r_state == S_SETTLE) ? r_rst_cnt + 1'b1 : '0;

            // Timing reset is visible exactly for the SETTLE cycles.
            if (r_state == S_APPLY) begin
                r_timing     <= w_rom;
                r_cur_mode   <= r_sel;
                r_act_pix    <= active_pix(w_rom);
                r_act_lines  <= active_lines(w_rom);
                r_timing_rst <= 1'b1;
            end else if ((r_state == S_SETTLE) && (w_next == S_UNBLANK)) begin
                r_timing_rst <= 1'b0;
            end
        end
    end

    assign mode_ack           = r_ack;
    assign mode_done          = r_done;
    assign busy               = (r_state != S_IDLE);
    assign timing_rst         = r_timing_rst;
    assign blank              = r_blank;
    assign cur_mode           = r_cur_mode;
    assign interlaced         = r_timing.interlaced;
    assign v_total_0          = r_timing.v_total_0;
    assign v_fp_0             = r_timing.v_fp_0;
    assign v_bp_0             = r_timing.v_bp_0;
    assign v_sync_0           = r_timing.v_sync_0;
    assign v_total_1          = r_timing.v_total_1;
    assign v_fp_1             = r_timing.v_fp_1;
    assign v_bp_1             = r_timing.v_bp_1;
    assign v_sync_1           = r_timing.v_sync_1;
    assign h_total            = r_timing.h_total;
    assign h_fp               = r_timing.h_fp;
    assign h_bp               = r_timing.h_bp;
    assign h_sync             = r_timing.h_sync;
    assign hv_offset_0        = r_timing.hv_offset_0;
    assign hv_offset_1        = r_timing.hv_offset_1;
    assign ramp_step          = r_timing.ramp_step;
    assign total_active_pix   = r_act_pix;
    assign total_active_lines = r_act_lines;

endmodule
`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_video_mode_ctrl
// Brief  : Randomized self-checking bench for video_mode_ctrl against a
//          frame-event reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_video_mode_ctrl;

    localparam int c_BLANK_FRAMES = 2;
    localparam int c_RST_CYCLES   = 4;
    localparam int c_TIMEOUT      = 64;
    localparam int c_N_EDGES      = c_BLANK_FRAMES + 2;

    logic        clk_in   = 1'b0;
    logic        reset    = 1'b1;
    logic        mode_req = 1'b0;
    logic        vs_in    = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        mode_ack, mode_done, busy, timing_rst, blank, interlaced;
    logic [1:0]  cur_mode;
    logic [11:0] v_total_0, v_fp_0, v_bp_0, v_sync_0;
    logic [11:0] v_total_1, v_fp_1, v_bp_1, v_sync_1;
    logic [11:0] h_total, h_fp, h_bp, h_sync, hv_offset_0, hv_offset_1;
    logic [11:0] total_active_pix, total_active_lines;
    logic [19:0] ramp_step;

    int         n_checks  = 0;
    int         n_errors  = 0;
    logic [1:0] model_cur = 2'd0;

    // Reference per-mode results: resolution and spec-given constants.
    int exp_h_total [4] = '{2200, 2200, 1650, 880};
    int exp_v_tot0  [4] = '{1125, 562, 750, 525};
    int exp_pix     [4] = '{1920, 1920, 1280, 720};
    int exp_lines   [4] = '{1080, 1080, 720, 480};
    int exp_step    [4] = '{'h222, 'h222, 'h333, 'h5B0};
    int exp_il      [4] = '{0, 1, 0, 0};
    int exp_off1    [4] = '{0, 1100, 0, 0};

    video_mode_ctrl #(
        .BLANK_FRAMES   (c_BLANK_FRAMES),
        .RST_CYCLES     (c_RST_CYCLES),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk_in (clk_in), .reset (reset), .mode_req (mode_req), .mode_sel (mode_sel),
        .mode_ack (mode_ack), .mode_done (mode_done), .busy (busy), .vs_in (vs_in),
        .timing_rst (timing_rst), .blank (blank), .cur_mode (cur_mode),
        .interlaced (interlaced),
        .v_total_0 (v_total_0), .v_fp_0 (v_fp_0), .v_bp_0 (v_bp_0), .v_sync_0 (v_sync_0),
        .v_total_1 (v_total_1), .v_fp_1 (v_fp_1), .v_bp_1 (v_bp_1), .v_sync_1 (v_sync_1),
        .h_total (h_total), .h_fp (h_fp), .h_bp (h_bp), .h_sync (h_sync),
        .hv_offset_0 (hv_offset_0), .hv_offset_1 (hv_offset_1),
        .total_active_pix (total_active_pix), .total_active_lines (total_active_lines),
        .ramp_step (ramp_step)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_mode(input logic [1:0] m);
        check_value("cur_mode", cur_mode, m);
        check_value("h_total", h_total, exp_h_total[m]);
        check_value("v_total_0", v_total_0, exp_v_tot0[m]);
        check_value("active_pix", total_active_pix, exp_pix[m]);
        check_value("active_lines", total_active_lines, exp_lines[m]);
        check_value("ramp_step", ramp_step, exp_step[m]);
        check_value("interlaced", interlaced, exp_il[m]);
        check_value("hv_offset_1", hv_offset_1, exp_off1[m]);
    endtask

    // Raise a request; returns at the sample point of the ack cycle
    // (or of the done cycle for a same-mode request).
    task automatic do_request(input logic [1:0] m, input bit edge_with_req);
        step();
        mode_sel = m;
        mode_req = 1'b1;
        vs_in    = edge_with_req;
        @(negedge clk_in);
        check_value("ack_before_accept", mode_ack, 0);
        step();
        @(negedge clk_in);
        check_value("ack_latency", mode_ack, 1);
        check_value("done_with_ack", mode_done, 0);
        mode_req = 1'b0;
        if (m == model_cur) begin
            step();
            @(negedge clk_in);
            check_value("same_mode_done", mode_done, 1);
            check_value("same_mode_blank", blank, 0);
            check_value("same_mode_busy", busy, 0);
        end else begin
            check_value("blank_on_accept", blank, 1);
            check_value("busy_on_accept", busy, 1);
        end
    endtask

    // Drive the frame edges of an accepted switch; optionally hold a second
    // request pending throughout. Starts at the sample point of the ack cycle.
    task automatic run_switch(input logic [1:0] m, input bit pend, input logic [1:0] pm);
        int e [c_N_EDGES];
        int w;
        int last;
        int tr_first   = -1;
        int tr_cnt     = 0;
        int done_at    = -1;
        int done_cnt   = 0;
        int blank_fall = -1;
        int early_ack  = 0;
        int busy_done  = -1;
        e[0] = $urandom_range(2, 20);
        for (int i = 1; i < c_N_EDGES; i++) begin
            e[i] = e[i-1] + $urandom_range(c_RST_CYCLES + 6, 30);
        end
        w    = $urandom_range(1, 3);
        last = e[c_N_EDGES-1] + 2;
        for (int c = 1; c <= last; c++) begin
            step();
            vs_in = 1'b0;
            for (int i = 0; i < c_N_EDGES; i++) begin
                if (c >= e[i] && c < e[i] + w) vs_in = 1'b1;
            end
            if (pend && c == 1) begin
                mode_req = 1'b1;
                mode_sel = pm;
            end
            @(negedge clk_in);
            if (timing_rst) begin
                if (tr_first < 0) tr_first = c;
                tr_cnt++;
            end
            if (mode_done) begin
                done_cnt++;
                done_at = c;
            end
            if (!blank && blank_fall < 0) blank_fall = c;
            if (mode_ack && c <= e[c_N_EDGES-1] + 1) early_ack++;
            if (c == e[c_N_EDGES-1] + 1) busy_done = busy;
        end
        check_value("trst_start", tr_first, e[c_N_EDGES-2] + 2);
        check_value("trst_len", tr_cnt, c_RST_CYCLES);
        check_value("done_count", done_cnt, 1);
        check_value("done_cycle", done_at, e[c_N_EDGES-1] + 1);
        check_value("blank_fall", blank_fall, e[c_N_EDGES-1] + 1);
        check_value("busy_at_done", busy_done, 0);
        check_value("ack_while_busy", early_ack, 0);
        if (pend) begin
            check_value("pending_ack", mode_ack, 1);
            mode_req = 1'b0;
        end
        model_cur = m;
        check_mode(m);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0] m;
        logic [1:0] a;
        logic [1:0] b;
        int         done_at;
        int         saw_done;

        repeat (3) step();
        reset = 1'b0;
        repeat (100) step();
        @(negedge clk_in);
        check_value("rst_busy", busy, 0);
        check_value("rst_blank", blank, 0);
        check_value("rst_trst", timing_rst, 0);
        check_value("rst_ack", mode_ack, 0);
        check_value("rst_done", mode_done, 0);
        check_mode(2'd0);

        do_request(2'd2, 1'b0);
        run_switch(2'd2, 1'b0, 2'd0);
        do_request(2'd1, 1'b1);
        run_switch(2'd1, 1'b0, 2'd0);
        do_request(2'd1, 1'b0);

        for (int it = 0; it < 8; it++) begin
            m = 2'($urandom_range(0, 3));
            do_request(m, 1'($urandom_range(0, 1)));
            if (m != model_cur) run_switch(m, 1'b0, 2'd0);
        end

        a = model_cur + 2'd1;
        b = model_cur + 2'd2;
        do_request(a, 1'b0);
        run_switch(a, 1'b1, b);
        check_value("pend_blank_on", blank, 1);
        check_value("pend_busy_on", busy, 1);
        run_switch(b, 1'b0, 2'd0);

        if (model_cur == 2'd0) begin
            do_request(2'd3, 1'b0);
            run_switch(2'd3, 1'b0, 2'd0);
        end
        do_request(model_cur + 2'd1, 1'b0);
        saw_done = 0;
        step(); vs_in = 1'b1;
        step(); vs_in = 1'b0;
        repeat (3) begin
            step();
            @(negedge clk_in);
            saw_done += int'(mode_done);
        end
        check_value("in_blank_state", blank, 1);
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        @(negedge clk_in);
        model_cur = 2'd0;
        check_value("midrst_busy", busy, 0);
        check_value("midrst_blank", blank, 0);
        check_value("midrst_trst", timing_rst, 0);
        check_mode(2'd0);
        for (int c = 0; c < 40; c++) begin
            step();
            vs_in = (c % 10 == 3);
            @(negedge clk_in);
            saw_done += int'(mode_done);
        end
        check_value("midrst_no_done", saw_done, 0);
        check_value("midrst_idle", busy, 0);

        do_request(2'd3, 1'b0);
        vs_in   = 1'b0;
        done_at = -1;
`ifdef VMC_TIMEOUT_EN
        for (int c = 1; c <= 2000 && done_at < 0; c++) begin
            step();
            @(negedge clk_in);
            if (mode_done) done_at = c;
        end
        check_value("timeout_done_cycle", done_at,
                    (c_BLANK_FRAMES + 2) * c_TIMEOUT + 1 + c_RST_CYCLES);
        model_cur = 2'd3;
        check_value("timeout_blank", blank, 0);
        check_mode(2'd3);
`else
        for (int c = 1; c <= 600; c++) begin
            step();
            @(negedge clk_in);
            if (mode_done && done_at < 0) done_at = c;
        end
        check_value("no_vs_done", done_at, -1);
        check_value("no_vs_busy", busy, 1);
        check_value("no_vs_blank", blank, 1);
        check_value("no_vs_mode", cur_mode, model_cur);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
